yuv444_to_yuv422_axis: RTL and testbench
========================================

# yuv444_to_yuv422_axis

Parametrised, AXI-Stream-handshaked YUV444 to YUV422 converter for the palette/video output path. It accepts one 4:4:4 pixel per beat and emits one 4:2:2 beat per pixel as {C, Y}, alternating U (even pixel) and V (odd pixel). Chroma is either cosited-dropped or pair-averaged with rounding, selected per frame. Unlike the fixed two-pixel, cen-gated converter, it supports backpressure, SOF/EOL sideband, odd-length lines and a runtime mode.

## Interface
- DATA_WIDTH, 8, bits per component (Y, U, V).
- FIFO_DEPTH, 4, output buffer entries; fixed at 4, must be ≥ 4.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = DROP (chroma taken from even pixel), 1 = AVERAGE; sampled only on the SOF beat.
- s_axis_tdata  in  3*DATA_WIDTH  {V, U, Y}, with Y in the LSBs.
- s_axis_tuser  in  1  start of frame; valid on the first pixel of the frame.
- s_axis_tlast  in  1  end of line.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  2*DATA_WIDTH  {C, Y}, with Y in the LSBs; C = U on even beats, V on odd beats.
- m_axis_tuser  out  1  set on the first output beat of the frame.
- m_axis_tlast  out  1  set on the last output beat of the line.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

## Operation
- Input phase register `phase` takes the values EVEN and ODD.
  - It toggles on every accepted beat.
  - It forces to EVEN after an accepted beat with tlast = 1.
  - An accepted tuser beat is always treated as EVEN, regardless of the current phase.
- EVEN beat without tlast:
  - Y, U, V, tuser and the latched mode go into the hold register; the hold-valid flag sets.
  - Nothing is pushed to the FIFO.
- ODD beat (hold valid): push 2 FIFO entries in the same cycle.
  - Entry 0 = {Cu, Y_even}, carrying the held tuser, tlast = 0.
  - Entry 1 = {Cv, Y_odd}, tuser = 0, tlast = input tlast.
  - DROP mode: Cu = U_even, Cv = V_even.
  - AVERAGE mode: Cu = (U_even + U_odd + 1) >> 1 and Cv = (V_even + V_odd + 1) >> 1.
  - Sums are DATA_WIDTH+1 bits wide; the result is the top DATA_WIDTH bits, so there is no overflow.
- EVEN beat with tlast (odd-length line):
  - Push 1 entry {U, Y} with tlast = 1; tuser is passed through.
  - No averaging is applied in either mode; phase stays EVEN.
- Mode latch:
  - Loads `mode` on an accepted beat with tuser = 1.
  - Reset value is 0 (DROP).
  - Changes on `mode` mid-frame are ignored.
- s_axis_tready = (fifo_count ≤ FIFO_DEPTH − 2), computed from registered count only; there is no combinational path from m_axis_tready.
- FIFO behaviour:
  - Push (1 or 2 entries) and pop may occur in the same cycle.
  - Next count = count + pushes − pop.
  - Entries keep their order.
- m_axis_tvalid = (count ≠ 0). A pop happens when tvalid && m_axis_tready.
- m_axis_tdata/tuser/tlast must hold stable while tvalid = 1 and tready = 0.

## Timing
- Latency: a pair whose odd pixel is accepted at edge N gives entry 0 valid at m_axis in cycle N+1 (when the FIFO was empty), and entry 1 at N+2 or later.
- Throughput: 1 output beat per cycle sustained when m_axis_tready = 1 and the input supplies 1 beat per cycle.
- Reset (takes effect on the clock edge where rst = 1):
  - FIFO count = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0.
  - Hold register and hold-valid cleared; phase = EVEN; mode latch = 0.
  - s_axis_tready = 1 from the first cycle after reset.
  - Reset mid-pair discards the held even pixel and all buffered entries; no partial output appears after reset.
- SOF arriving while phase = ODD (truncated line):
  - The held pixel is flushed as a single entry with tlast = 1, pushed in the same cycle as the new pixel is stored into hold.
  - This counts as 1 push; it is allowed only under the same s_axis_tready rule.

## Structure
- Package `yuv422_pkg`:
  - MODE_DROP = 1'b0, MODE_AVERAGE = 1'b1.
  - Phase enumeration {EVEN, ODD}.
  - Function for the rounded average, parametrised by width.
- Sub-module `yuv422_out_fifo`:
  - Register-based, FIFO_DEPTH entries.
  - 0/1/2-entry push port and 1 pop port.
  - Exposes count.
  - Entry = {tuser, tlast, C, Y}.
- Top level holds the phase FSM, hold register, mode latch and chroma arithmetic.

## Test plan
- Reset then AVERAGE, 2-pixel line: SOF pixel (Y=10,U=100,V=200), then (Y=20,U=101,V=51,tlast) -> m_axis beats {101,10} tuser=1 and {126,20} tlast=1. Rounding: (100+101+1)>>1 = 101 and (200+51+1)>>1 = 126.
- DROP mode on the same stimulus -> {100,10} and {200,20}.
- Overflow check, AVERAGE, U = 255 and 255 with V = 255 and 0 -> C = 255 and 128; no wrap.
- 3-pixel line ending in tlast -> 3 beats, with the last = {U2, Y2} and tlast=1; the next line starts on an even-phase U beat.
- m_axis_tready held 0 for 10 cycles with a continuous input burst:
  - s_axis_tready drops once count > 2.
  - Output data stays stable while stalled.
  - No beat is lost or duplicated over 64 random pixels compared against the model.
- `mode` toggled mid-frame is ignored until the next tuser. rst asserted between the even and odd pixels gives no output beats and tvalid = 0 on the next cycle.

Source files
------------

// File: rtl/yuv422_pkg.sv
// yuv422_pkg: shared mode constants, input phase type and rounded chroma average
package yuv422_pkg;
  localparam logic MODE_DROP = 1'b0;
  localparam logic MODE_AVERAGE = 1'b1;
  localparam int AVG_W = 16;
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;
  // Rounded mean of two components up to AVG_W bits; the one-bit-wider sum cannot wrap
  function automatic logic [AVG_W-1:0] round_avg(input logic [AVG_W-1:0] a, input logic [AVG_W-1:0] b);
    return AVG_W'(({1'b0, a} + {1'b0, b} + {{AVG_W{1'b0}}, 1'b1}) >> 1);
  endfunction
endpackage

// File: rtl/yuv422_out_fifo.sv
// yuv422_out_fifo: register FIFO accepting up to two pushes and one pop per cycle
module yuv422_out_fifo #(
  parameter int W = 18,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    push_n,
  input  logic [W-1:0]  d0,
  input  logic [W-1:0]  d1,
  input  logic          pop,
  output logic [W-1:0]  q,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, wp1, wp2, rp1;
  assign wp1 = wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
  assign wp2 = wp1 == AW'(DEPTH - 1) ? '0 : wp1 + 1'b1;
  assign rp1 = rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
  assign q = mem[rp];
  // Storage and pointers; d0 always lands before d1 so entry order is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push_n != 2'd0) mem[wp] <= d0;
      if (push_n == 2'd2) mem[wp1] <= d1;
      wp <= push_n == 2'd2 ? wp2 : push_n == 2'd1 ? wp1 : wp;
      rp <= pop ? rp1 : rp;
      count <= count + CW'(push_n) - CW'(pop);
    end
  end
endmodule

// File: rtl/yuv444_to_yuv422_axis.sv
// yuv444_to_yuv422_axis: AXI-Stream 4:4:4 to 4:2:2 converter with drop/average chroma
module yuv444_to_yuv422_axis
  import yuv422_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [3*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);
  localparam int DW = DATA_WIDTH;
  localparam int EW = 2 * DW + 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  phase_t phase;
  logic mode_q, huser, hmode;
  logic [DW-1:0] hy, hu, hv, in_y, in_u, in_v, cu, cv;
  logic acc, even_beat, pair, store, flush, single;
  logic [1:0] push_n;
  logic [EW-1:0] d0, d1, q;
  logic [CW-1:0] count;
  assign in_y = s_axis_tdata[DW-1:0];
  assign in_u = s_axis_tdata[2*DW-1:DW];
  assign in_v = s_axis_tdata[3*DW-1:2*DW];
  assign s_axis_tready = count <= CW'(FIFO_DEPTH - 2);
  assign acc = s_axis_tvalid && s_axis_tready;
  assign even_beat = phase == EVEN || s_axis_tuser;
  assign pair = acc && !even_beat;
  assign store = acc && even_beat && !s_axis_tlast;
  assign flush = acc && phase == ODD && s_axis_tuser;
  assign single = acc && even_beat && s_axis_tlast;
  assign cu = hmode == MODE_AVERAGE ? DW'(round_avg(AVG_W'(hu), AVG_W'(in_u))) : hu;
  assign cv = hmode == MODE_AVERAGE ? DW'(round_avg(AVG_W'(hv), AVG_W'(in_v))) : hv;
  // A truncated line's held pixel is flushed ahead of any single-pixel line end in the same beat
  always_comb begin
    push_n = pair ? 2'd2 : 2'(flush) + 2'(single);
    d0 = pair ? {huser, 1'b0, cu, hy} : flush ? {huser, 1'b1, hu, hy} : {s_axis_tuser, 1'b1, in_u, in_y};
    d1 = pair ? {1'b0, s_axis_tlast, cv, in_y} : {s_axis_tuser, 1'b1, in_u, in_y};
  end
  // Phase, frame mode latch and even-pixel hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= EVEN;
      mode_q <= MODE_DROP;
      hy <= '0;
      hu <= '0;
      hv <= '0;
      huser <= 1'b0;
      hmode <= MODE_DROP;
    end else begin
      phase <= acc ? (store ? ODD : EVEN) : phase;
      if (acc && s_axis_tuser) mode_q <= mode;
      if (store) begin
        hy <= in_y;
        hu <= in_u;
        hv <= in_v;
        huser <= s_axis_tuser;
        hmode <= s_axis_tuser ? mode : mode_q;
      end
    end
  end
  yuv422_out_fifo #(.W(EW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_n(push_n),
    .d0(d0),
    .d1(d1),
    .pop(m_axis_tvalid && m_axis_tready),
    .q(q),
    .count(count)
  );
  assign m_axis_tvalid = count != '0;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = q;
endmodule

// File: tb/tb_yuv444_to_yuv422_axis.sv
// tb_yuv444_to_yuv422_axis: randomized line-level model check of the 4:2:2 converter
module tb_yuv444_to_yuv422_axis;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic [23:0] s_tdata = '0;
  logic s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [15:0] m_tdata;
  logic m_tuser, m_tlast, m_tvalid;
  logic m_tready = 1'b0;
  typedef struct {logic [23:0] d; logic u; logic l; logic m;} beat_t;
  beat_t in_q[$];
  logic [17:0] exp_q[$];
  logic [7:0] ly[$], lu[$], lv[$];
  logic l_user;
  int n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  yuv444_to_yuv422_axis dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int ravg(input int a, input int b);
    return (a + b + 1) / 2;
  endfunction

  task automatic add_pix(input int y, input int u, input int v, input bit sof, input bit last, input bit m);
    beat_t b;
    b.d = {8'(v), 8'(u), 8'(y)};
    b.u = sof;
    b.l = last;
    b.m = m;
    in_q.push_back(b);
    if (ly.size() == 0) l_user = sof;
    ly.push_back(8'(y));
    lu.push_back(8'(u));
    lv.push_back(8'(v));
  endtask

  task automatic end_line(input bit last, input bit fm);
    int n = ly.size();
    int c0, c1;
    for (int i = 0; i + 1 < n; i += 2) begin
      c0 = fm ? ravg(int'(lu[i]), int'(lu[i+1])) : int'(lu[i]);
      c1 = fm ? ravg(int'(lv[i]), int'(lv[i+1])) : int'(lv[i]);
      exp_q.push_back({1'(i == 0 && l_user), 1'b0, 8'(c0), ly[i]});
      exp_q.push_back({1'b0, 1'(last && i + 2 == n), 8'(c1), ly[i+1]});
    end
    if (n % 2 == 1) exp_q.push_back({1'(n == 1 && l_user), 1'b1, lu[n-1], ly[n-1]});
    ly.delete();
    lu.delete();
    lv.delete();
  endtask

  task automatic rand_line(input int n, input bit sof, input bit last, input bit fm);
    for (int i = 0; i < n; i++)
      add_pix($urandom_range(255), $urandom_range(255), $urandom_range(255), sof && i == 0,
              last && i == n - 1, (sof && i == 0) ? fm : 1'($urandom_range(1)));
    end_line(last, fm);
  endtask

  task automatic gen_random(input int npix);
    int total = 0;
    while (total < npix) begin
      bit fm = 1'($urandom_range(1));
      int nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        int n = $urandom_range(1, 6);
        bit last;
        total += n;
        last = (l < nl - 1) || (total >= npix) || 1'($urandom_range(1));
        rand_line(n, l == 0, last, fm);
      end
    end
  endtask

  task automatic drive_front();
    s_tdata = in_q[0].d;
    s_tuser = in_q[0].u;
    s_tlast = in_q[0].l;
    mode = in_q[0].m;
  endtask

  task automatic run(input int vp, input int rp, input int stall_n);
    int cyc = 0;
    bit stalled = 0;
    logic [17:0] prev = '0, cur;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cur = {m_tuser, m_tlast, m_tdata};
      if (stalled) begin
        check_eq("stall_hold", 32'(cur), 32'(prev));
        check_eq("stall_valid", 32'(m_tvalid), 32'd1);
      end
      if (stall_n > 0 && cyc == stall_n) check_eq("tready_drop", 32'(s_tready), 32'd0);
      s_tvalid = in_q.size() > 0 && (cyc < stall_n || $urandom_range(99) < vp);
      if (in_q.size() > 0) drive_front();
      m_tready = cyc >= stall_n && $urandom_range(99) < rp;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() > 0) check_eq("beat", 32'(cur), 32'(exp_q.pop_front()));
        else check_eq("extra_beat", 32'(m_tvalid), 32'd0);
      end
      if (s_tvalid && s_tready) void'(in_q.pop_front());
      stalled = m_tvalid && !m_tready;
      prev = cur;
      cyc++;
    end
    check_eq("drained", 32'(in_q.size() + exp_q.size()), 32'd0);
    @(negedge clk);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_valid", 32'(m_tvalid), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_tdata), 32'd0);
    check_eq("rst_tuser", 32'(m_tuser), 32'd0);
    check_eq("rst_tlast", 32'(m_tlast), 32'd0);
    check_eq("rst_tready", 32'(s_tready), 32'd1);
    // AVERAGE two-pixel line with hand-stepped latency checks
    add_pix(10, 100, 200, 1, 0, 1);
    add_pix(20, 101, 51, 0, 1, 0);
    end_line(1, 1);
    drive_front();
    s_tvalid = 1'b1;
    void'(in_q.pop_front());
    @(negedge clk);
    check_eq("lat_even", 32'(m_tvalid), 32'd0);
    drive_front();
    void'(in_q.pop_front());
    @(negedge clk);
    s_tvalid = 1'b0;
    check_eq("lat_pair", 32'(m_tvalid), 32'd1);
    check_eq("avg_beat0", 32'({m_tuser, m_tlast, m_tdata}), 32'({1'b1, 1'b0, 8'd101, 8'd10}));
    run(100, 100, 0);
    // DROP on the same pixels
    add_pix(10, 100, 200, 1, 0, 0);
    add_pix(20, 101, 51, 0, 1, 1);
    end_line(1, 0);
    run(100, 100, 0);
    // Saturating sums in AVERAGE
    add_pix(1, 255, 255, 1, 0, 1);
    add_pix(2, 255, 0, 0, 1, 0);
    end_line(1, 1);
    run(100, 100, 0);
    // Odd-length line followed by a fresh even-phase line
    rand_line(3, 1, 1, 1);
    rand_line(2, 0, 1, 1);
    run(100, 100, 0);
    // Mid-frame mode toggles ignored, then a new SOF switches mode
    add_pix(5, 10, 20, 1, 0, 0);
    add_pix(6, 30, 40, 0, 0, 1);
    add_pix(7, 50, 60, 0, 0, 1);
    add_pix(8, 70, 80, 0, 1, 1);
    end_line(1, 0);
    rand_line(4, 1, 1, 1);
    run(100, 100, 0);
    // Truncated odd line flushed by the next SOF
    rand_line(3, 1, 0, 0);
    rand_line(2, 1, 1, 1);
    run(80, 80, 0);
    // Output stall with a continuous input burst
    rand_line(8, 1, 1, 1);
    run(100, 100, 10);
    // Random traffic with random backpressure
    gen_random(64);
    run(70, 60, 0);
    // Reset between even and odd pixel discards the pending pair
    @(negedge clk);
    s_tdata = 24'h112233;
    s_tuser = 1'b1;
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("midrst_tready", 32'(s_tready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_idle", 32'(m_tvalid), 32'd0);
    end
    rand_line(2, 1, 1, 1);
    run(100, 100, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
